rs_15_11_encoder: RTL and testbench

RS_15_11_ENCODER -- requirements
Module: rs_15_11_encoder

---
 rtl/rs_gf16_pkg.sv | 29 ++
 rtl/gf16_mul.sv | 24 ++
 rtl/rs_15_11_encoder.sv | 127 ++++++++++++
 tb/tb_rs_15_11_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf16_pkg.sv
// Shared GF(16) / RS(15,11) definitions for the encoder and decoder.
// Field: x^4 + x + 1, alpha = 0x2.
package rs_gf16_pkg;

    localparam int unsigned N     = 15;
    localparam int unsigned K     = 11;
    localparam int unsigned SYM_W = 4;
    localparam int unsigned NPAR  = N - K;
    localparam int unsigned CNT_W = 4;

    localparam logic [SYM_W:0] PRIM_POLY = 5'h13;

    // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^1..alpha^4
    localparam logic [SYM_W-1:0] G0 = 4'h7;
    localparam logic [SYM_W-1:0] G1 = 4'h8;
    localparam logic [SYM_W-1:0] G2 = 4'hC;
    localparam logic [SYM_W-1:0] G3 = 4'hD;

    typedef enum logic [0:0] {
        StData,
        StParity
    } enc_state_e;

    // Multiply by alpha with reduction modulo the primitive polynomial.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] a);
        return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
    endfunction

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(16) multiplier (shift-and-add over x^4 + x + 1).
module gf16_mul
    import rs_gf16_pkg::*;
(
    input  logic [SYM_W-1:0] A,
    input  logic [SYM_W-1:0] B,
    output logic [SYM_W-1:0] P
);

    always_comb begin
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] sh;
        acc = '0;
        sh  = A;
        for (int i = 0; i < SYM_W; i++) begin
            if (B[i]) begin
                acc = acc ^ sh;
            end
            sh = gf_xtime(sh);
        end
        P = acc;
    end

endmodule

// File: rtl/rs_15_11_encoder.sv
// Systematic RS(15,11) encoder: 11 message symbols pass through, then parity p3..p0.
// Define RS_ENC_ERR_INJ_EN to add the ERR_MASK port that corrupts output symbols.
module rs_15_11_encoder
    import rs_gf16_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [SYM_W-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [SYM_W-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST
`ifdef RS_ENC_ERR_INJ_EN
    ,
    input  logic [SYM_W-1:0] ERR_MASK
`endif
);

    localparam logic [NPAR-1:0][SYM_W-1:0] GEN_COEF = {G3, G2, G1, G0};

    enc_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NPAR-1:0][SYM_W-1:0]  lfsr_q, lfsr_d;
    logic [SYM_W-1:0]            out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;

    logic                        slot_free;
    logic                        in_fire;
    logic [SYM_W-1:0]            fb;
    logic [NPAR-1:0][SYM_W-1:0]  fb_prod;
    logic [SYM_W-1:0]            err_mask;

`ifdef RS_ENC_ERR_INJ_EN
    assign err_mask = ERR_MASK;
`else
    assign err_mask = '0;
`endif

    // Output register is empty or its symbol leaves this cycle.
    assign slot_free = !out_valid_q || OUT_READY;
    assign IN_READY  = (state_q == StData) && slot_free;
    assign in_fire   = IN_VALID && IN_READY;
    assign fb        = IN_DATA ^ lfsr_q[NPAR-1];

    for (genvar i = 0; i < NPAR; i++) begin : g_mul
        gf16_mul u_mul (
            .A (fb),
            .B (GEN_COEF[i]),
            .P (fb_prod[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            StData: begin
                if (in_fire) begin
                    out_data_d  = IN_DATA ^ err_mask;
                    out_valid_d = 1'b1;
                    lfsr_d      = {lfsr_q[NPAR-2:0], {SYM_W{1'b0}}} ^ fb_prod;
                    if (cnt_q == CNT_W'(K - 1)) begin
                        state_d = StParity;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (slot_free) begin
                    out_data_d  = lfsr_q[NPAR-1] ^ err_mask;
                    out_valid_d = 1'b1;
                    lfsr_d      = {lfsr_q[NPAR-2:0], {SYM_W{1'b0}}};
                    if (cnt_q == CNT_W'(NPAR - 1)) begin
                        // Four shifts have flushed the LFSR to zero by now.
                        out_last_d = 1'b1;
                        state_d    = StData;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StData;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StData;
            cnt_q       <= '0;
            lfsr_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_rs_15_11_encoder.sv
// Scoreboard bench for rs_15_11_encoder: reference model uses log/antilog GF(16) tables
// and long division by a generator built from its roots.
module tb_rs_15_11_encoder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       OUT_LAST;
    logic [3:0] err_mask_drv;

    always #5 CLK = ~CLK;

    rs_15_11_encoder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST)
`ifdef RS_ENC_ERR_INJ_EN
        ,
        .ERR_MASK  (err_mask_drv)
`endif
    );

    typedef struct packed {
        logic [3:0] d;
        logic       last;
        logic       inj;
    } sb_t;

    int         n_cmp = 0;
    int         n_err = 0;
    sb_t        sb[$];
    logic [3:0] in_q[$];
    logic [3:0] msg[$];
    logic [3:0] gexp[15];
    int         glog[16];
    logic [3:0] gen[5];
    logic [3:0] cw[15];
    logic [3:0] last_cw[15];
    logic [3:0] ref_cw[15];
    logic       cw_inj = 1'b0;
    int         out_idx = 0;
    int         cw_num = 0;
    int         out_total = 0;
    logic [14:0] stall_mask = '0;
    int         stall_left = 0;
    int         stall_key = -1;
    logic [3:0] held = '0;
    logic       holding = 1'b0;
    int         run = 0;
    int         max_run = 0;
    logic       inj_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    task automatic init_field();
        logic [3:0] x;
        gexp[0] = 4'h1;
        glog[0] = 0;
        glog[1] = 0;
        for (int i = 1; i < 15; i++) begin
            x       = gexp[i-1];
            gexp[i] = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
            glog[gexp[i]] = i;
        end
        // g(x) = prod (x + alpha^r), r = 1..4; gen[k] is the x^k coefficient
        gen = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int r = 1; r <= 4; r++) begin
            for (int k = 4; k >= 0; k--) begin
                gen[k] = gmul(gexp[r], gen[k]) ^ ((k > 0) ? gen[k-1] : 4'h0);
            end
        end
    endtask

    // Message accepted by the DUT: push expected output, and parity after the 11th.
    task automatic accept(input logic [3:0] d, input logic [3:0] m);
        sb_t        e;
        logic [3:0] c[15];
        logic [3:0] coef;
        msg.push_back(d);
        e.d = d ^ m; e.last = 1'b0; e.inj = (m != 4'h0);
        sb.push_back(e);
        if (msg.size() == 11) begin
            for (int i = 0; i < 15; i++) c[i] = 4'h0;
            for (int k = 0; k < 11; k++) c[14-k] = msg[k];
            for (int i = 14; i >= 4; i--) begin
                coef = c[i];
                for (int j = 0; j <= 4; j++) c[i-4+j] = c[i-4+j] ^ gmul(coef, gen[j]);
            end
            for (int p = 3; p >= 0; p--) begin
                e.d = c[p]; e.last = (p == 0); e.inj = 1'b0;
                sb.push_back(e);
            end
            msg.delete();
        end
    endtask

    task automatic finish_codeword();
        logic [3:0] s;
        for (int i = 0; i < 15; i++) last_cw[i] = cw[i];
        if (!cw_inj) begin
            for (int j = 1; j <= 4; j++) begin
                s = 4'h0;
                for (int i = 0; i < 15; i++) s = gmul(s, gexp[j]) ^ cw[i];
                check_eq($sformatf("syndrome_s%0d_cw%0d", j, cw_num), s, 0);
            end
        end
        cw_inj = 1'b0;
    endtask

    task automatic tick();
        sb_t e;
        @(negedge CLK);
        if (stall_left > 0) begin
            OUT_READY = 1'b0;
            stall_left--;
        end else if (OUT_VALID && stall_mask[out_idx] && stall_key != cw_num * 16 + out_idx) begin
            OUT_READY  = 1'b0;
            stall_key  = cw_num * 16 + out_idx;
            stall_left = 2;
        end else begin
            OUT_READY = 1'b1;
        end
        IN_VALID     = (in_q.size() != 0);
        IN_DATA      = IN_VALID ? in_q[0] : 4'($urandom);
        err_mask_drv = 4'h0;
        #1;
        if (inj_on && IN_VALID && IN_READY && msg.size() == 0) err_mask_drv = 4'h3;

        if (OUT_VALID && !OUT_READY) begin
            if (holding) check_eq("stall_out_data_hold", OUT_DATA, held);
            check_eq("stall_in_ready", IN_READY, 0);
            held    = OUT_DATA;
            holding = 1'b1;
        end else begin
            holding = 1'b0;
        end

        if (OUT_VALID && OUT_READY) begin
            run++;
            if (run > max_run) max_run = run;
            if (sb.size() == 0) begin
                check_eq("spurious_out", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq($sformatf("out_data_cw%0d_i%0d", cw_num, out_idx), OUT_DATA, e.d);
                check_eq($sformatf("out_last_cw%0d_i%0d", cw_num, out_idx), OUT_LAST, e.last);
                cw_inj = cw_inj | e.inj;
            end
            cw[out_idx] = OUT_DATA;
            out_total++;
            if (out_idx == 14) begin
                finish_codeword();
                out_idx = 0;
                cw_num++;
            end else begin
                out_idx++;
            end
        end else begin
            run = 0;
        end

        if (IN_VALID && IN_READY) begin
            void'(in_q.pop_front());
            accept(IN_DATA, err_mask_drv);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || in_q.size() != 0) && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) check_eq("drain_timeout", sb.size() + in_q.size(), 0);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) tick();
        check_eq("reset_out_valid", OUT_VALID, 0);
        check_eq("reset_out_data", OUT_DATA, 0);
        check_eq("reset_out_last", OUT_LAST, 0);
        RESET = 1'b0;
        check_eq("reset_in_ready", IN_READY, 1);
        sb.delete();
        msg.delete();
        out_idx   = 0;
        cw_inj    = 1'b0;
        out_total = 0;
    endtask

    task automatic push_unit_msg();
        for (int i = 0; i < 10; i++) in_q.push_back(4'h0);
        in_q.push_back(4'h1);
    endtask

    task automatic check_unit_parity(input string tag);
        check_eq({tag, "_p3"}, last_cw[11], 4'hD);
        check_eq({tag, "_p2"}, last_cw[12], 4'hC);
        check_eq({tag, "_p1"}, last_cw[13], 4'h8);
        check_eq({tag, "_p0"}, last_cw[14], 4'h7);
    endtask

    initial begin
        int guard;
        RESET        = 1'b1;
        IN_DATA      = 4'h0;
        IN_VALID     = 1'b0;
        OUT_READY    = 1'b1;
        err_mask_drv = 4'h0;
        init_field();

        do_reset();

        // All-zero message
        for (int i = 0; i < 11; i++) in_q.push_back(4'h0);
        drain();
        check_eq("zero_cw_count", out_total, 15);

        // Unit message: parity equals the generator coefficients
        push_unit_msg();
        drain();
        check_unit_parity("unit");

        // Message 1..B, checked by model and syndromes
        for (int i = 1; i <= 11; i++) in_q.push_back(4'(i));
        drain();
        for (int i = 0; i < 15; i++) ref_cw[i] = last_cw[i];

        // Same message with 3-cycle stalls at data symbol 5 and parity symbol 2
        stall_mask[5]  = 1'b1;
        stall_mask[13] = 1'b1;
        for (int i = 1; i <= 11; i++) in_q.push_back(4'(i));
        drain();
        stall_mask = '0;
        for (int i = 0; i < 15; i++) check_eq($sformatf("stall_vs_ref_%0d", i), last_cw[i], ref_cw[i]);

        // Reset after 6 symbols, then a full unit message
        for (int i = 1; i <= 6; i++) in_q.push_back(4'(i));
        guard = 0;
        while (in_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check_eq("partial_feed_timeout", in_q.size(), 0);
        do_reset();
        push_unit_msg();
        drain();
        check_eq("after_reset_count", out_total, 15);
        check_unit_parity("after_reset");

        // Two codewords back to back, no gaps expected
`ifdef RS_ENC_ERR_INJ_EN
        inj_on = 1'b1;
`endif
        max_run = 0;
        run     = 0;
        for (int i = 1; i <= 11; i++) in_q.push_back(4'(i));
        for (int i = 0; i < 11; i++) in_q.push_back(4'($urandom));
        drain();
        inj_on = 1'b0;
        check_eq("b2b_run", max_run, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
